seq_mult: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 8 +
 rtl/seq_mult_if.sv | 12 +
 rtl/seq_mult_addn.sv | 30 +++
 rtl/seq_mult.sv | 92 +++++++++
 tb/tb_seq_mult.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared state encoding for the sequential shift-add multiplier.
package seq_mult_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/seq_mult_if.sv
// Start/busy/done handshake and operand/product bus for seq_mult.
interface seq_mult_if #(parameter int WIDTH = 16);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_addn.sv
// Ripple-carry adder built from full-adder cells; carry-out is dropped.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module addn #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);
    logic [WIDTH-1:0] c;

    assign c[0] = 1'b0;

    // The MSB needs no carry-out, so it is a bare XOR instead of a full cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < WIDTH-1) begin : g_fa
            fa u_fa (.a_i(a_i[i]), .b_i(b_i[i]), .c_i(c[i]), .s_o(sum_o[i]), .c_o(c[i+1]));
        end else begin : g_msb
            assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        end
    end
endmodule

// File: rtl/seq_mult.sv
// WIDTH-bit sequential shift-add multiplier, fixed WIDTH-cycle latency,
// optional two's-complement mode via sign-magnitude conversion.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_mult_if.slave bus
);
    localparam int PW = 2*WIDTH;
    localparam int CW = $clog2(WIDTH+1);

    state_e          state_q;
    logic [PW-1:0]   acc_q, mcand_q, product_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]   count_q;
    logic            neg_q, busy_q, done_q;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    sum, acc_d, product_d;

    addn #(.WIDTH(PW)) u_add (.a_i(acc_q), .b_i(mcand_q), .sum_o(sum));

    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
        if (SIGNED != 0) begin
            if (bus.a[WIDTH-1]) mag_a = -bus.a;
            if (bus.b[WIDTH-1]) mag_b = -bus.b;
        end
        acc_d     = mplier_q[0] ? sum : acc_q;
        product_d = neg_q ? -acc_d : acc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        count_q  <= CW'(WIDTH);
                        neg_q    <= (SIGNED != 0) ? (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) : 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q - CW'(1);
                    // Product captures the final partial sum on this edge.
                    if (count_q == CW'(1)) begin
                        product_q <= product_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: three instances (16u, 16s, 4u), per-instance scoreboard
// with cycle-exact done/busy prediction.
module tb_seq_mult;
    logic clk, rst_n;
    int   cyc = 0;
    int   n_chk = 0, n_err = 0;
    bit   mon_on = 0;

    typedef struct { logic [31:0] prod; int dcyc; } sb_t;
    typedef struct { int id; logic [15:0] a; logic [15:0] b; logic [31:0] exp; } vec_t;

    sb_t         sbq[3][$];
    logic [31:0] last_prod[3];

    vec_t tv[8] = '{
        '{0, 16'd3,    16'd5,    32'h0000000F},
        '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001},
        '{0, 16'h0000, 16'h1234, 32'h00000000},
        '{1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1},
        '{1, 16'h8000, 16'h8000, 32'h40000000},
        '{1, 16'hFFF9, 16'hFFF7, 32'h0000003F},
        '{1, 16'h7FFF, 16'h8000, 32'hC0008000},
        '{2, 16'h000F, 16'h000F, 32'h000000E1}
    };

    seq_mult_if #(.WIDTH(16)) if0 ();
    seq_mult_if #(.WIDTH(16)) if1 ();
    seq_mult_if #(.WIDTH(4))  if2 ();

    seq_mult #(.WIDTH(16), .SIGNED(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    seq_mult #(.WIDTH(16), .SIGNED(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq_mult #(.WIDTH(4),  .SIGNED(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    function automatic int wid(int id);
        return (id == 2) ? 4 : 16;
    endfunction

    function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b, int w, bit sgn);
        longint sa, sb, p;
        logic [63:0] u;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        u = p;
        u = u & ((64'd1 << (2*w)) - 64'd1);
        return u[31:0];
    endfunction

    task automatic chk(string nm, int id, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc %0d: got %h required %h", nm, id, cyc, got, exp);
        end
    endtask

    task automatic mon(int id, logic bz, logic dn, logic [31:0] pr);
        bit be = 0, de = 0;
        int w = wid(id);
        if (sbq[id].size() > 0) begin
            be = (cyc >= sbq[id][0].dcyc - w) && (cyc < sbq[id][0].dcyc);
            de = (cyc == sbq[id][0].dcyc);
        end
        chk("busy", id, 32'(bz), 32'(be));
        chk("done", id, 32'(dn), 32'(de));
        if (de) begin
            chk("product", id, pr, sbq[id][0].prod);
            last_prod[id] = sbq[id][0].prod;
            void'(sbq[id].pop_front());
        end else if (!be) begin
            chk("hold", id, pr, last_prod[id]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, if0.busy, if0.done, if0.product);
            mon(1, if1.busy, if1.done, if1.product);
            mon(2, if2.busy, if2.done, 32'(if2.product));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int id, bit st, logic [15:0] a, logic [15:0] b);
        case (id)
            0: begin if0.start = st; if0.a = a; if0.b = b; end
            1: begin if1.start = st; if1.a = a; if1.b = b; end
            default: begin if2.start = st; if2.a = a[3:0]; if2.b = b[3:0]; end
        endcase
    endtask

    task automatic push(int id, logic [31:0] p);
        sb_t e;
        e.prod = p;
        e.dcyc = cyc + wid(id) + 1;
        sbq[id].push_back(e);
    endtask

    task automatic drain(int id);
        int t = 0;
        while (sbq[id].size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (sbq[id].size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout dut%0d: got %0d pending results required 0", id, sbq[id].size());
            sbq[id].delete();
        end
    endtask

    // Operands are scrambled right after capture; the result must not care.
    task automatic op(int id, logic [15:0] a, logic [15:0] b, logic [31:0] exp);
        drv(id, 1'b1, a, b);
        push(id, exp);
        tick();
        drv(id, 1'b0, ~a, ~b);
        drain(id);
    endtask

    // start held high; DUT should accept exactly every w+2 cycles.
    task automatic cont(int id, bit sgn, int nops, bit sweep);
        int w = wid(id);
        int p = w + 2;
        logic [15:0] ra, rb;
        for (int k = 0; k < nops*p; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (w == 4) begin ra &= 16'h000F; rb &= 16'h000F; end
            if (k % p == 0) begin
                if (sweep) begin
                    ra = 16'((k/p) >> 4);
                    rb = 16'((k/p) & 15);
                end
                push(id, ref_mul(ra, rb, w, sgn));
            end
            drv(id, 1'b1, ra, rb);
            tick();
        end
        drv(id, 1'b0, 16'h0, 16'h0);
        drain(id);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(i, 1'b0, 16'h0, 16'h0);
            last_prod[i] = '0;
        end
        repeat (3) tick();
        chk("rst_busy", 0, 32'(if0.busy), 0);
        chk("rst_done", 0, 32'(if0.done), 0);
        chk("rst_prod", 0, if0.product, 0);
        chk("rst_busy", 1, 32'(if1.busy), 0);
        chk("rst_prod", 1, if1.product, 0);
        chk("rst_prod", 2, 32'(if2.product), 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) op(tv[i].id, tv[i].a, tv[i].b, tv[i].exp);

        cont(0, 1'b0, 6, 1'b0);
        cont(1, 1'b1, 6, 1'b0);

        // Abort mid-RUN: no done pulse may follow.
        mon_on = 1'b0;
        drv(0, 1'b1, 16'd3, 16'd5);
        tick();
        drv(0, 1'b0, 16'h0, 16'h0);
        repeat (7) tick();
        chk("busy_pre_rst", 0, 32'(if0.busy), 1);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 0, 32'(if0.busy), 0);
        chk("abort_done", 0, 32'(if0.done), 0);
        chk("abort_prod", 0, if0.product, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) last_prod[i] = '0;
        mon_on = 1'b1;
        repeat (25) tick();
        op(0, 16'd6, 16'd7, 32'd42);

        cont(2, 1'b0, 256, 1'b1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
